// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter.
// The header-prefix option is enabled by defining UART_ARB_ID_PREFIX_EN.
package uart_pkg;

   localparam logic [3:0] HDR_TAG = 4'hA;
   localparam int MAX_REQ = 16;
   localparam int ID_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      START_HDR,
      WAIT_HDR,
      START,
      WAIT
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the last winner.
// Priority starts at last+1 and wraps modulo N_REQ.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_last,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_winner
);

   logic [2*N_REQ-1:0] dbl;
   logic [2*N_REQ-1:0] shifted;
   logic [N_REQ-1:0]   rot;
   logic [ID_W:0]      shamt;
   int                 off;
   int                 win;

   // rot[i] holds request (last+1+i) mod N_REQ
   always_comb begin
      shamt   = {1'b0, i_last} + 5'd1;
      dbl     = {i_req, i_req};
      shifted = dbl >> shamt;
      rot     = shifted[N_REQ-1:0];
   end

   always_comb begin
      off = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = i;
         end
      end
      win      = (int'(i_last) + 1 + off) % N_REQ;
      o_valid  = |i_req;
      o_winner = ID_W'(win);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte sources.
// Define UART_ARB_ID_PREFIX_EN to send a {HDR_TAG, id} header before each byte.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic               i_clk,
   input  logic               i_aresetn,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_data,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_busy,
   input  logic               i_tx_done,
   output logic [3:0]         o_grant_id,
   output logic               o_busy,
   output logic               o_timeout
);

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 2);
   localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);
   localparam logic [3:0]      LAST_RST = 4'(N_REQ - 1);

   state_t             state_q, state_d;
   logic [3:0]         grant_q, grant_d;
   logic [3:0]         last_q, last_d;
   logic [7:0]         data_q, data_d;
   logic [N_REQ-1:0]   ready_q, ready_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               tout_q, tout_d;
   logic [TO_W-1:0]    wd_q, wd_d;
`ifdef UART_ARB_ID_PREFIX_EN
   logic [7:0]         pay_q, pay_d;
`endif

   logic               arb_valid;
   logic [3:0]         arb_winner;
   logic [N_REQ-1:0]   win_oh;
   logic [7:0]         sel_byte;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .i_req    (i_req_valid),
      .i_last   (last_q),
      .o_valid  (arb_valid),
      .o_winner (arb_winner)
   );

   always_comb begin
      win_oh   = '0;
      sel_byte = '0;
      for (int k = 0; k < N_REQ; k++) begin
         win_oh[k] = (arb_winner == 4'(k));
         if (grant_q == 4'(k)) begin
            sel_byte = i_req_data[8*k +: 8];
         end
      end
   end

   // o_tx_start is registered, so the pulse is scheduled one cycle ahead
   // from the busy level seen in ACCEPT/START.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      data_d  = data_q;
      ready_d = '0;
      start_d = 1'b0;
      tout_d  = 1'b0;
      wd_d    = wd_q;
`ifdef UART_ARB_ID_PREFIX_EN
      pay_d   = pay_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_winner;
               ready_d = win_oh;
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            last_d  = grant_q;
            start_d = ~i_tx_busy;
`ifdef UART_ARB_ID_PREFIX_EN
            data_d  = {HDR_TAG, grant_q};
            pay_d   = sel_byte;
            state_d = START_HDR;
`else
            data_d  = sel_byte;
            state_d = START;
`endif
         end
`ifdef UART_ARB_ID_PREFIX_EN
         START_HDR: begin
            if (start_q) begin
               wd_d    = '0;
               state_d = WAIT_HDR;
            end else begin
               start_d = ~i_tx_busy;
            end
         end
         WAIT_HDR: begin
            wd_d = wd_q + WD_ONE;
            if (i_tx_done) begin
               data_d  = pay_q;
               state_d = START;
            end else if (wd_q == WD_LAST) begin
               tout_d  = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         START: begin
            if (start_q) begin
               wd_d    = '0;
               state_d = WAIT;
            end else begin
               start_d = ~i_tx_busy;
            end
         end
         WAIT: begin
            wd_d = wd_q + WD_ONE;
            if (i_tx_done) begin
               state_d = IDLE;
            end else if (wd_q == WD_LAST) begin
               tout_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         data_q  <= '0;
         ready_q <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         tout_q  <= 1'b0;
         wd_q    <= '0;
`ifdef UART_ARB_ID_PREFIX_EN
         pay_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
         wd_q    <= wd_d;
`ifdef UART_ARB_ID_PREFIX_EN
         pay_q   <= pay_d;
`endif
      end
   end

   assign o_req_ready = ready_q;
   assign o_tx_data   = data_q;
   assign o_tx_start  = start_q;
   assign o_grant_id  = grant_q;
   assign o_busy      = busy_q;
   assign o_timeout   = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, corner sequences, random vs model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int TO = 100;

   logic          clk;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [31:0]   req_data;
   logic [NR-1:0] o_req_ready;
   logic [7:0]    o_tx_data;
   logic          o_tx_start;
   logic          tx_busy;
   logic          tx_done;
   logic [3:0]    o_grant_id;
   logic          o_busy;
   logic          o_timeout;

   int checks = 0;
   int errors = 0;
   int model_last;

   uart_tx_arbiter #(
      .N_REQ          (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk       (clk),
      .i_aresetn   (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (o_req_ready),
      .o_tx_data   (o_tx_data),
      .o_tx_start  (o_tx_start),
      .i_tx_busy   (tx_busy),
      .i_tx_done   (tx_done),
      .o_grant_id  (o_grant_id),
      .o_busy      (o_busy),
      .o_timeout   (o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] data;
      int          exp_id;
      logic [7:0]  exp_byte;
      int          dly;
      bit          no_done;
      int          hold;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] m, input int last);
      for (int i = 1; i <= NR; i++) begin
         int c;
         c = (last + i) % NR;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   task automatic wait_start(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_tx_start && n < 20);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_req_ready, 0);
      chk("rst_start", o_tx_start, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_grant", o_grant_id, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_timeout", o_timeout, 0);
      rst_n = 1'b1;
      model_last = NR - 1;
      @(negedge clk);
   endtask

   task automatic do_txn(input logic [3:0] mask, input logic [31:0] data,
                         input int exp_id, input logic [7:0] exp_byte,
                         input int dly, input bit no_done, input int hold,
                         input bit keep);
      int nf;
      int n;
      bit bad;
      logic [7:0] fb;
      nf = 1;
`ifdef UART_ARB_ID_PREFIX_EN
      nf = 2;
`endif
      req_valid = mask;
      req_data  = data;
      tx_busy   = (hold > 0);
      @(negedge clk);
      chk("ready", o_req_ready, 32'd1 << exp_id);
      chk("grant_id", o_grant_id, exp_id);
      chk("busy_accept", o_busy, 1);
      if (hold > 0) begin
         bad = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_tx_start) bad = 1;
         end
         chk("hold_no_start", bad, 0);
         tx_busy = 1'b0;
      end
      for (int f = 0; f < nf; f++) begin
         fb = (nf == 2 && f == 0) ? {4'hA, 4'(exp_id)} : exp_byte;
         wait_start(n);
         chk("start_latency", n, 1);
         chk("tx_data", o_tx_data, fb);
         chk("ready_quiet", o_req_ready, 0);
         if (!keep) req_valid = '0;
         if (no_done) begin
            bad = 0;
            for (int i = 1; i < TO; i++) begin
               @(negedge clk);
               if (o_timeout || o_tx_start) bad = 1;
            end
            @(negedge clk);
            chk("timeout_early", bad, 0);
            chk("timeout_pulse", o_timeout, 1);
            chk("busy_after_to", o_busy, 0);
            return;
         end
         repeat (dly) @(negedge clk);
         chk("data_hold", o_tx_data, fb);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         chk("busy_after_done", o_busy, (f == nf - 1) ? 1'b0 : 1'b1);
         chk("no_timeout", o_timeout, 0);
      end
   endtask

   vec_t vecs[8];

   initial begin
      vec_t v;
      int id;
      int n;
      logic [3:0] m;
      logic [31:0] d;

      vecs[0] = '{4'b0100, 32'h005A_0000, 2, 8'h5A, 5, 0, 0};
      vecs[1] = '{4'b1111, 32'h1312_1110, 3, 8'h13, 1, 0, 0};
      vecs[2] = '{4'b1111, 32'h1312_1110, 0, 8'h10, 12, 0, 0};
      vecs[3] = '{4'b0110, 32'h1312_1110, 1, 8'h11, 0, 1, 0};
      vecs[4] = '{4'b0110, 32'h1312_1110, 2, 8'h12, 3, 0, 0};
      vecs[5] = '{4'b1001, 32'h1312_1110, 3, 8'h13, 7, 0, 0};
      vecs[6] = '{4'b1001, 32'h1312_1110, 0, 8'h10, 2, 0, 0};
      vecs[7] = '{4'b1000, 32'hAB00_0000, 3, 8'hAB, 0, 1, 50};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         do_txn(v.mask, v.data, v.exp_id, v.exp_byte, v.dly, v.no_done,
                v.hold, 1'b0);
      end

      // Fairness: all four held continuously, back-to-back grants
      do_reset();
      for (int i = 0; i < 5; i++) begin
         id = rr_pick(4'b1111, model_last);
         do_txn(4'b1111, 32'h1312_1110, id, 8'(8'h10 + id),
                3 + i, 0, 0, 1'b1);
         model_last = id;
      end
      req_valid = '0;
      @(negedge clk);

      // Randomized grants checked against the round-robin model
      for (int r = 0; r < 40; r++) begin
         m  = 4'($urandom_range(1, 15));
         d  = $urandom;
         id = rr_pick(m, model_last);
         n  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
         do_txn(m, d, id, d[8*id +: 8], $urandom_range(1, 30),
                ($urandom_range(0, 9) == 0), n, 1'b0);
         model_last = id;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Asynchronous reset while waiting for done
      req_valid = 4'b0100;
      req_data  = 32'h0077_0000;
      @(negedge clk);
      chk("mid_ready", o_req_ready, 4'b0100);
      req_valid = '0;
      wait_start(n);
      chk("mid_start", o_tx_start, 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", o_req_ready, 0);
      chk("arst_start", o_tx_start, 0);
      chk("arst_data", o_tx_data, 0);
      chk("arst_grant", o_grant_id, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_timeout", o_timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_last = NR - 1;
      @(negedge clk);
      do_txn(4'b1111, 32'h4433_2211, 0, 8'h11, 4, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
